sky130_fd_io__xres_drv_ctl: RTL and testbench

//  Transmit-side controller for an open-drain external-reset line (XRES pad).
//  On request, pulls the pad low for a guaranteed minimum width, longer than the receive-side glitch filter.

---
 rtl/sky130_fd_io__xres_drv_ctl.sv | 193 +++++++++++++++++++
 tb/tb_sky130_fd_io__xres_drv_ctl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sky130_fd_io__xres_drv_ctl.sv
// -----------------------------------------------------------------------------
// sky130_fd_io__xres_drv_ctl
//
// Transmit-side controller for an open-drain external-reset (XRES) pad.
// A request pulls the pad low for exactly PULSE_CYCLES clocks. This is long
// enough to pass the receive-side glitch filter. The pull-down is then
// released, and the controller waits for the pad readback to return high.
// If the readback has not returned high by RELEASE_TIMEOUT, the sequence ends
// with the sticky TIMEOUT_H flag set.
//
// Configuration macro:
//   SKY130_FD_IO_XRES_DRV_SYNC_EN
//     defined   : PAD_IN_H goes through a 2-flop synchronizer (reset to 0).
//                 Release detection lags the pad by 2 cycles.
//     undefined : PAD_IN_H is used directly and must be synchronous to CLK.
//
// Parameters:
//   PULSE_CYCLES     cycles PAD_PD_H is held high per request (>= 1)
//   RELEASE_TIMEOUT  last RELEASE counter value before giving up (>= 1)
//   CNT_W            counter width, must hold max(PULSE_CYCLES, RELEASE_TIMEOUT)
//
// Ports:
//   CLK        in   rising-edge clock
//   RESET_N    in   asynchronous active-low reset
//   REQ_H      in   level request for a reset pulse, sampled only in IDLE
//   ACK_H      out  1-cycle pulse: request accepted
//   PAD_IN_H   in   pad readback
//   PAD_PD_H   out  1 = pad pull-down enabled (pad driven low)
//   BUSY_H     out  1 while a sequence is in progress
//   DONE_H     out  1-cycle pulse: sequence finished (release seen or timeout)
//   TIMEOUT_H  out  sticky: the last sequence ended by timeout
// -----------------------------------------------------------------------------
module sky130_fd_io__xres_drv_ctl #(
  parameter int unsigned PULSE_CYCLES    = 64,
  parameter int unsigned RELEASE_TIMEOUT = 255,
  parameter int unsigned CNT_W           = 8
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic REQ_H,
  output logic ACK_H,
  input  logic PAD_IN_H,
  output logic PAD_PD_H,
  output logic BUSY_H,
  output logic DONE_H,
  output logic TIMEOUT_H
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] PULSE_LIM = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(RELEASE_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             ack_q, ack_d;
  logic             pd_q, pd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             rb;

  // ---------------------------------------------------------------------------
  // Pad readback
  // ---------------------------------------------------------------------------
`ifdef SKY130_FD_IO_XRES_DRV_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], PAD_IN_H};

  // The synchronizer resets low. After reset, a pad that is already high
  // takes two cycles to appear on rb. That is harmless, because rb is only
  // consulted in RELEASE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign rb = sync_q[1];
`else
  assign rb = PAD_IN_H;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    pd_d      = pd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    // The counter saturates instead of wrapping.
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        // PAD_IN_H is deliberately ignored here, because another agent may
        // legitimately hold the line low.
        if (REQ_H) begin
          state_d   = ST_ASSERT;
          ack_d     = 1'b1;
          pd_d      = 1'b1;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          // The counter starts at 1, so comparing against PULSE_LIM gives a
          // pull-down width of exactly PULSE_CYCLES.
          cnt_d     = CNT_ONE;
        end
      end

      ST_ASSERT: begin
        if (cnt_q == PULSE_LIM) begin
          state_d = ST_RELEASE;
          pd_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RELEASE: begin
        // The readback is tested first, so a release seen on the timeout
        // cycle still counts as a clean finish.
        if (rb) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LIM) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pd_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, and ordering races between processes are avoided.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      pd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      pd_q      <= pd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // All outputs come straight from flops, so there is no input-to-output
  // combinational path. The pull-down also drops as soon as reset asserts.
  assign ACK_H     = ack_q;
  assign PAD_PD_H  = pd_q;
  assign BUSY_H    = busy_q;
  assign DONE_H    = done_q;
  assign TIMEOUT_H = timeout_q;

endmodule

// File: tb/tb_sky130_fd_io__xres_drv_ctl.sv
// -----------------------------------------------------------------------------
// Testbench for sky130_fd_io__xres_drv_ctl.
//
// Instance u_dut uses the default parameters (64-cycle pulse, 255 timeout).
// Instance u_small uses PULSE_CYCLES=1 and RELEASE_TIMEOUT=1 for the
// release-versus-timeout race. The stimulus pushes expected ACK, DONE and
// pull-down-width events into queues. A monitor sampling on the falling edge
// pops and compares them whenever the DUT presents one.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sky130_fd_io__xres_drv_ctl;

`ifdef SKY130_FD_IO_XRES_DRV_SYNC_EN
  localparam int L = 2;   // readback detection latency in cycles
`else
  localparam int L = 0;
`endif
  localparam int PULSE = 64;
  localparam int RT    = 255;

  typedef struct {
    int dut;
    int cyc;
    int val;
  } ev_t;

  logic CLK = 1'b0;
  logic RESET_N;
  logic req0, req1;
  logic pad0_follow, pad0_force, pad1;
  logic pad0;
  logic ack0, pd0, busy0, done0, tmo0;
  logic ack1, pd1, busy1, done1, tmo1;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  ev_t ack_q[$];
  ev_t done_q[$];
  ev_t pdw_q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // The pad is either pulled low by the DUT or pulled up externally, unless
  // the bench forces a level to emulate a line held low.
  assign pad0 = pad0_follow ? !pd0 : pad0_force;

  sky130_fd_io__xres_drv_ctl u_dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .REQ_H     (req0),
    .ACK_H     (ack0),
    .PAD_IN_H  (pad0),
    .PAD_PD_H  (pd0),
    .BUSY_H    (busy0),
    .DONE_H    (done0),
    .TIMEOUT_H (tmo0)
  );

  sky130_fd_io__xres_drv_ctl #(
    .PULSE_CYCLES    (1),
    .RELEASE_TIMEOUT (1),
    .CNT_W           (8)
  ) u_small (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .REQ_H     (req1),
    .ACK_H     (ack1),
    .PAD_IN_H  (pad1),
    .PAD_PD_H  (pd1),
    .BUSY_H    (busy1),
    .DONE_H    (done1),
    .TIMEOUT_H (tmo1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push_ev(input int kind, input int dut, input int c, input int v);
    ev_t e;
    e.dut = dut;
    e.cyc = c;
    e.val = v;
    case (kind)
      0:       ack_q.push_back(e);
      1:       done_q.push_back(e);
      default: pdw_q.push_back(e);
    endcase
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (!busy0 && !busy1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every presented output event against the scoreboard
  // ---------------------------------------------------------------------------
  int pd_run[2] = '{0, 0};

  always @(negedge CLK) begin
    logic ack_v[2];
    logic done_v[2];
    logic pd_v[2];
    logic tmo_v[2];
    ev_t  e;
    ack_v[0]  = ack0;  ack_v[1]  = ack1;
    done_v[0] = done0; done_v[1] = done1;
    pd_v[0]   = pd0;   pd_v[1]   = pd1;
    tmo_v[0]  = tmo0;  tmo_v[1]  = tmo1;
    for (int d = 0; d < 2; d++) begin
      if (ack_v[d]) begin
        if (ack_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL ack_unexpected: dut %0d acked at cycle %0d, none expected", d, cyc);
        end else begin
          e = ack_q.pop_front();
          check("ack_dut", d, e.dut);
          check("ack_cycle", cyc, e.cyc);
        end
      end
      if (done_v[d]) begin
        if (done_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL done_unexpected: dut %0d done at cycle %0d, none expected", d, cyc);
        end else begin
          e = done_q.pop_front();
          check("done_dut", d, e.dut);
          check("done_cycle", cyc, e.cyc);
          check("done_timeout", tmo_v[d], e.val);
        end
      end
      if (pd_v[d]) begin
        pd_run[d]++;
      end else if (pd_run[d] != 0) begin
        if (pdw_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL pd_unexpected: dut %0d pulse width %0d, none expected", d, pd_run[d]);
        end else begin
          e = pdw_q.pop_front();
          check("pd_dut", d, e.dut);
          check("pd_width", pd_run[d], e.val);
        end
        pd_run[d] = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int a;
    int a_last;
    RESET_N     = 1'b0;
    req0        = 1'b0;
    req1        = 1'b0;
    pad0_follow = 1'b1;
    pad0_force  = 1'b0;
    pad1        = 1'b0;

    tick(3);
    check("rst_ack",     ack0,  0);
    check("rst_pd",      pd0,   0);
    check("rst_busy",    busy0, 0);
    check("rst_done",    done0, 0);
    check("rst_timeout", tmo0,  0);
    check("rst_small_pd", pd1,  0);
    RESET_N = 1'b1;
    tick(3);

    // 1: single request with the pad following the pull-down.
    a = cyc + 1;
    push_ev(0, 0, a, 0);
    push_ev(2, 0, 0, PULSE);
    push_ev(1, 0, a + PULSE + 1 + L, 0);
    req0 = 1'b1;
    tick(1);
    req0 = 1'b0;
    check("t1_pd_on_accept",   pd0,   1);
    check("t1_busy_on_accept", busy0, 1);
    wait_idle("t1_idle", 400);
    check("t1_timeout", tmo0, 0);
    tick(2);

    // 2: pad held low. A low pad in IDLE has no effect. After release the
    //    sequence times out: the last RELEASE cycle has count RT, so DONE
    //    arrives RT+1 edges after RELEASE is entered.
    pad0_follow = 1'b0;
    pad0_force  = 1'b0;
    tick(5);
    check("t2_idle_pad_low_busy", busy0, 0);
    check("t2_idle_pad_low_pd",   pd0,   0);
    a = cyc + 1;
    push_ev(0, 0, a, 0);
    push_ev(2, 0, 0, PULSE);
    push_ev(1, 0, a + PULSE + RT + 1, 1);
    req0 = 1'b1;
    tick(1);
    req0 = 1'b0;
    wait_idle("t2_idle", 600);
    check("t2_busy_after", busy0, 0);
    check("t2_timeout",    tmo0,  1);
    tick(3);
    check("t2_timeout_sticky", tmo0, 1);

    // 3: requests during ASSERT cycles 10 and 40 are ignored. The accepted
    //    request clears the sticky timeout.
    pad0_follow = 1'b1;
    tick(3);
    a = cyc + 1;
    push_ev(0, 0, a, 0);
    push_ev(2, 0, 0, PULSE);
    push_ev(1, 0, a + PULSE + 1 + L, 0);
    req0 = 1'b1;
    tick(1);
    req0 = 1'b0;
    check("t3_timeout_cleared", tmo0, 0);
    tick(9);
    req0 = 1'b1;
    tick(1);
    req0 = 1'b0;
    tick(29);
    req0 = 1'b1;
    tick(1);
    req0 = 1'b0;
    wait_idle("t3_idle", 400);
    tick(2);

    // 4: request held high. Each new ACK lands on the edge after DONE.
    a = cyc + 1;
    a_last = a;
    for (int i = 0; i < 3; i++) begin
      push_ev(0, 0, a, 0);
      push_ev(2, 0, 0, PULSE);
      push_ev(1, 0, a + PULSE + 1 + L, 0);
      a_last = a;
      a = a + PULSE + 2 + L;
    end
    req0 = 1'b1;
    tick(a_last - cyc);
    req0 = 1'b0;
    wait_idle("t4_idle", 400);
    tick(2);

    // 5: reset at the start of ASSERT cycle 20. The pull-down was seen high
    //    at 19 falling edges, and no DONE follows.
    a = cyc + 1;
    push_ev(0, 0, a, 0);
    push_ev(2, 0, 0, 19);
    req0 = 1'b1;
    tick(1);
    req0 = 1'b0;
    tick(19);
    RESET_N = 1'b0;
    #1;
    check("t5_pd_async_drop", pd0,   0);
    check("t5_busy_reset",    busy0, 0);
    tick(2);
    RESET_N = 1'b1;
    tick(5);
    check("t5_idle_busy", busy0, 0);
    check("t5_idle_pd",   pd0,   0);
    a = cyc + 1;
    push_ev(0, 0, a, 0);
    push_ev(2, 0, 0, PULSE);
    push_ev(1, 0, a + PULSE + 1 + L, 0);
    req0 = 1'b1;
    tick(1);
    req0 = 1'b0;
    wait_idle("t5_restart_idle", 400);
    tick(2);

    // 6a: minimal parameters, with the readback never returning. RELEASE is
    //     entered at a+1 and times out in its second cycle.
    a = cyc + 1;
    push_ev(0, 1, a, 0);
    push_ev(2, 1, 0, 1);
    push_ev(1, 1, a + 3, 1);
    req1 = 1'b1;
    tick(1);
    req1 = 1'b0;
    wait_idle("t6a_idle", 20);
    check("t6a_timeout", tmo1, 1);
    tick(2);

    // 6b: rb rises exactly on the timeout cycle, so the release wins.
    a = cyc + 1;
    push_ev(0, 1, a, 0);
    push_ev(2, 1, 0, 1);
    push_ev(1, 1, a + 3, 0);
    req1 = 1'b1;
    tick(1);
    req1 = 1'b0;
    tick(2 - L);
    pad1 = 1'b1;
    wait_idle("t6b_idle", 20);
    check("t6b_timeout", tmo1, 0);

    tick(4);
    check("ack_q_drained",  ack_q.size(),  0);
    check("done_q_drained", done_q.size(), 0);
    check("pdw_q_drained",  pdw_q.size(),  0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
